// File: rtl/rpn_stack_eval.sv
// rpn_stack_eval
// Evaluates a stream of reverse-Polish instructions on an internal stack and
// emits one result (value + error code) per program, where END closes a program.
//
// Ports
//   clk         single clock, all state changes on its rising edge
//   rst         asynchronous active-high reset
//   in_valid    instruction present
//   in_ready    block accepts an instruction (high in RUN and DRAIN)
//   in_op       opcode: 0 PUSH, 1 ADD, 2 SUB, 3 MUL, 4 NEG, 5 DUP, 6 POP, 7 END
//   in_operand  immediate value for PUSH, ignored for other opcodes
//   res_valid   result present (high only in EMIT)
//   res_ready   consumer accepts the result
//   res_data    program result
//   res_err     0 OK, 1 UNDERFLOW, 2 OVERFLOW, 3 BAD_END
//   depth       current stack occupancy
module rpn_stack_eval #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [DATA_W-1:0]      in_operand,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_W-1:0]      res_data,
  output logic [1:0]             res_err,
  output logic [$clog2(DEPTH):0] depth
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_NEG  = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_POP  = 3'd6;
  localparam logic [2:0] OP_END  = 3'd7;

  localparam logic [1:0] ERR_OK        = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_BAD_END   = 2'd3;

  localparam logic [AW:0] D_ONE  = {{AW{1'b0}}, 1'b1};
  // DEPTH is a power of two, so "full" is just the MSB of the occupancy count.
  localparam logic [AW:0] D_FULL = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t              r_state, w_state_next;
  logic [AW:0]         r_depth, w_depth_next;
  logic [1:0]          r_err, w_err_next;
  logic [DATA_W-1:0]   r_res_data, w_res_data_next;
  logic [1:0]          r_res_err, w_res_err_next;

  logic [DATA_W-1:0]   r_stack [DEPTH];

  logic                w_accept;
  logic [AW-1:0]       w_top_idx, w_sec_idx;
  logic [DATA_W-1:0]   w_top, w_sec;
  logic                w_empty, w_lt2, w_full;
  logic                w_need1, w_need2, w_grow;
  logic                w_underflow, w_overflow;
  logic                w_wr_en;
  logic [AW-1:0]       w_wr_idx;
  logic [DATA_W-1:0]   w_wr_data;

  assign in_ready  = (r_state != S_EMIT);
  assign res_valid = (r_state == S_EMIT);
  assign res_data  = r_res_data;
  assign res_err   = r_res_err;
  assign depth     = r_depth;

  assign w_accept = in_valid && in_ready;

  // Indices wrap modulo DEPTH; at full occupancy the top index wraps to
  // DEPTH-1 correctly, and in under-occupied cases the read is unused.
  assign w_top_idx = r_depth[AW-1:0] - D_ONE[AW-1:0];
  assign w_sec_idx = w_top_idx - D_ONE[AW-1:0];
  assign w_top     = r_stack[w_top_idx];
  assign w_sec     = r_stack[w_sec_idx];

  assign w_empty = (r_depth == '0);
  assign w_lt2   = (r_depth[AW:1] == '0);
  assign w_full  = (r_depth == D_FULL);

  assign w_need2 = (in_op == OP_ADD) || (in_op == OP_SUB) || (in_op == OP_MUL);
  assign w_need1 = (in_op == OP_NEG) || (in_op == OP_DUP) || (in_op == OP_POP);
  assign w_grow  = (in_op == OP_PUSH) || (in_op == OP_DUP);

  // Underflow is checked first so DUP on an empty stack reports UNDERFLOW.
  assign w_underflow = (w_need2 && w_lt2) || (w_need1 && w_empty);
  assign w_overflow  = w_grow && w_full;

  always_comb begin
    w_state_next    = r_state;
    w_depth_next    = r_depth;
    w_err_next      = r_err;
    w_res_data_next = r_res_data;
    w_res_err_next  = r_res_err;
    w_wr_en         = 1'b0;
    w_wr_idx        = r_depth[AW-1:0];
    w_wr_data       = in_operand;

    case (r_state)
      S_RUN: begin
        if (w_accept) begin
          if (in_op == OP_END) begin
            w_state_next = S_EMIT;
            if (r_depth == D_ONE) begin
              w_res_data_next = w_top;
              w_res_err_next  = ERR_OK;
            end else begin
              w_res_data_next = '0;
              w_res_err_next  = ERR_BAD_END;
            end
          end else if (w_underflow) begin
            w_err_next   = ERR_UNDERFLOW;
            w_state_next = S_DRAIN;
          end else if (w_overflow) begin
            w_err_next   = ERR_OVERFLOW;
            w_state_next = S_DRAIN;
          end else begin
            case (in_op)
              OP_PUSH: begin
                w_wr_en      = 1'b1;
                w_depth_next = r_depth + D_ONE;
              end
              OP_ADD, OP_SUB, OP_MUL: begin
                // b is the top, a the entry below; result replaces a.
                w_wr_en  = 1'b1;
                w_wr_idx = w_sec_idx;
                if (in_op == OP_ADD)      w_wr_data = w_sec + w_top;
                else if (in_op == OP_SUB) w_wr_data = w_sec - w_top;
                else                      w_wr_data = w_sec * w_top;
                w_depth_next = r_depth - D_ONE;
              end
              OP_NEG: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = w_top_idx;
                w_wr_data = '0 - w_top;
              end
              OP_DUP: begin
                w_wr_en      = 1'b1;
                w_wr_data    = w_top;
                w_depth_next = r_depth + D_ONE;
              end
              OP_POP: begin
                w_depth_next = r_depth - D_ONE;
              end
              default: ;
            endcase
          end
        end
      end
      S_DRAIN: begin
        // Everything but END is swallowed after a fault.
        if (w_accept && (in_op == OP_END)) begin
          w_state_next    = S_EMIT;
          w_res_data_next = '0;
          w_res_err_next  = r_err;
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          w_state_next = S_RUN;
          w_depth_next = '0;
          w_err_next   = ERR_OK;
        end
      end
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_depth    <= '0;
      r_err      <= ERR_OK;
      r_res_data <= '0;
      r_res_err  <= ERR_OK;
    end else begin
      r_state    <= w_state_next;
      r_depth    <= w_depth_next;
      r_err      <= w_err_next;
      r_res_data <= w_res_data_next;
      r_res_err  <= w_res_err_next;
    end
  end

  // Stack contents above the occupancy are don't-care, so storage is not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_stack[w_wr_idx] <= w_wr_data;
    end
  end

endmodule

// File: tb/tb_rpn_stack_eval.sv
// tb_rpn_stack_eval
// Directed and randomized programs for rpn_stack_eval, checked against a
// queue-based stack model of the instruction set.
module tb_rpn_stack_eval;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_operand;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [1:0]        res_err;
  logic [4:0]        depth;

  rpn_stack_eval #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_operand (in_operand),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .depth      (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DATA_W-1:0] m_stk [$];
  logic              m_drain;
  logic [1:0]        m_err;
  logic              m_pend;
  logic [DATA_W-1:0] m_exp_data;
  logic [1:0]        m_exp_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_drain = 1'b0;
    m_err   = 2'd0;
    m_pend  = 1'b0;
  endtask

  task automatic model_fault(input logic [1:0] code);
    m_err   = code;
    m_drain = 1'b1;
  endtask

  task automatic model_emit(input logic [DATA_W-1:0] d, input logic [1:0] e);
    m_pend     = 1'b1;
    m_exp_data = d;
    m_exp_err  = e;
  endtask

  task automatic model_apply(input logic [2:0] op, input logic [DATA_W-1:0] opnd);
    logic [DATA_W-1:0] a, b, r;
    if (m_drain) begin
      if (op == 3'd7) model_emit('0, m_err);
    end else begin
      case (op)
        3'd0: if (m_stk.size() == DEPTH) model_fault(2'd2);
              else m_stk.push_back(opnd);
        3'd1, 3'd2, 3'd3: begin
          if (m_stk.size() < 2) model_fault(2'd1);
          else begin
            b = m_stk.pop_back();
            a = m_stk.pop_back();
            if (op == 3'd1)      r = a + b;
            else if (op == 3'd2) r = a - b;
            else                 r = a * b;
            m_stk.push_back(r);
          end
        end
        3'd4: if (m_stk.size() < 1) model_fault(2'd1);
              else begin
                r = 32'd0 - m_stk[$];
                m_stk[$] = r;
              end
        3'd5: if (m_stk.size() < 1) model_fault(2'd1);
              else if (m_stk.size() == DEPTH) model_fault(2'd2);
              else begin
                r = m_stk[$];
                m_stk.push_back(r);
              end
        3'd6: if (m_stk.size() < 1) model_fault(2'd1);
              else void'(m_stk.pop_back());
        default: begin
          if (m_stk.size() == 1) model_emit(m_stk[0], 2'd0);
          else model_emit('0, 2'd3);
        end
      endcase
    end
  endtask

  // Issue one instruction; the model advances only if the transfer happened.
  task automatic send(input logic [2:0] op, input logic [DATA_W-1:0] opnd);
    int cyc;
    cyc = 0;
    @(negedge clk);
    in_valid   = 1'b1;
    in_op      = op;
    in_operand = opnd;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (in_ready || cyc < 20) begin
      model_apply(op, opnd);
      check("depth_after_op", {59'd0, depth}, 64'(m_stk.size()));
    end
  endtask

  task automatic get_result();
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!res_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("res_pending_model", {63'd0, m_pend}, 64'd1);
    check("res_valid", {63'd0, res_valid}, 64'd1);
    check("res_data", {32'd0, res_data}, {32'd0, m_exp_data});
    check("res_err", {62'd0, res_err}, {62'd0, m_exp_err});
    check("in_ready_emit", {63'd0, in_ready}, 64'd0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    model_reset();
    check("res_valid_after", {63'd0, res_valid}, 64'd0);
    check("depth_after_res", {59'd0, depth}, 64'd0);
    check("in_ready_after", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_depth"}, {59'd0, depth}, 64'd0);
    check({tag, "_res_valid"}, {63'd0, res_valid}, 64'd0);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    check({tag, "_res_data"}, {32'd0, res_data}, 64'd0);
    check({tag, "_res_err"}, {62'd0, res_err}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] held;
    int len, pick;
    logic [2:0] op;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_op      = 3'd0;
    in_operand = '0;
    res_ready  = 1'b0;
    model_reset();

    #2;
    check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 3 4 + 5 * -> 35
    send(3'd0, 32'd3); send(3'd0, 32'd4); send(3'd1, 0);
    send(3'd0, 32'd5); send(3'd3, 0); send(3'd7, 0);
    check("model_35", {32'd0, m_exp_data}, 64'd35);
    get_result();

    // Wraparound cases
    send(3'd0, 32'hFFFF_FFFF); send(3'd0, 32'd2); send(3'd1, 0); send(3'd7, 0);
    get_result();
    send(3'd0, 32'd0); send(3'd4, 0); send(3'd7, 0);
    get_result();
    send(3'd0, 32'd1); send(3'd4, 0); send(3'd7, 0);
    get_result();
    send(3'd0, 32'd3); send(3'd0, 32'd10); send(3'd2, 0); send(3'd7, 0);
    get_result();

    // Underflow then drained PUSH
    send(3'd0, 32'd6); send(3'd1, 0); send(3'd0, 32'd9); send(3'd7, 0);
    get_result();

    // Overflow via DUP at full stack
    for (int i = 0; i < DEPTH; i++) send(3'd0, 32'(i + 1));
    send(3'd5, 0); send(3'd7, 0);
    get_result();

    // DUP on empty stack reports underflow
    send(3'd5, 0); send(3'd7, 0);
    get_result();

    // Bad END
    send(3'd0, 32'd1); send(3'd0, 32'd2); send(3'd7, 0);
    get_result();
    send(3'd7, 0);
    get_result();

    // Back-pressure: result held, no instruction accepted
    send(3'd0, 32'd4); send(3'd0, 32'd6); send(3'd3, 0); send(3'd7, 0);
    @(negedge clk);
    in_valid   = 1'b1;
    in_op      = 3'd0;
    in_operand = 32'd99;
    held       = m_exp_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_res_data", {32'd0, res_data}, {32'd0, held});
      check("hold_res_valid", {63'd0, res_valid}, 64'd1);
      check("hold_depth", {59'd0, depth}, 64'(m_stk.size()));
    end
    in_valid = 1'b0;
    get_result();
    send(3'd0, 32'd1); send(3'd7, 0);
    get_result();

    // Reset mid-program
    send(3'd0, 32'd7); send(3'd0, 32'd8);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    send(3'd0, 32'd2); send(3'd7, 0);
    get_result();

    // Reset while a result is pending
    send(3'd0, 32'd5); send(3'd7, 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("rst_emit");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized programs
    for (int p = 0; p < 40; p++) begin
      len = (p % 8 == 7) ? 20 : $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        pick = $urandom_range(0, 99);
        if (p % 8 == 7)   op = (pick < 90) ? 3'd0 : 3'd5;
        else if (pick < 40) op = 3'd0;
        else if (pick < 52) op = 3'd1;
        else if (pick < 62) op = 3'd2;
        else if (pick < 72) op = 3'd3;
        else if (pick < 80) op = 3'd4;
        else if (pick < 88) op = 3'd5;
        else if (pick < 96) op = 3'd6;
        else                op = 3'd7;
        send(op, (pick[0]) ? $urandom : 32'($urandom_range(0, 20)));
        if (m_pend) get_result();
      end
      if (!m_pend) send(3'd7, 0);
      get_result();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rpn_stack_eval.md
RPN_STACK_EVAL -- requirements
Module: rpn_stack_eval

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of operands, stack entries and result.
REQ-002 SHALL have parameter DEPTH, default 16, number of stack entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  instruction present.
REQ-006 SHALL have port in_ready  output  1  block accepts instruction this cycle.
REQ-007 SHALL have port in_op  input  3  opcode: 0 PUSH, 1 ADD, 2 SUB, 3 MUL, 4 NEG, 5 DUP, 6 POP, 7 END.
REQ-008 SHALL have port in_operand  input  DATA_W  immediate for PUSH; ignored otherwise.
REQ-009 SHALL have port res_valid  output  1  result present.
REQ-010 SHALL have port res_ready  input  1  consumer accepts result.
REQ-011 SHALL have port res_data  output  DATA_W  program result.
REQ-012 SHALL have port res_err  output  2  0 OK, 1 UNDERFLOW, 2 OVERFLOW, 3 BAD_END.
REQ-013 SHALL have port depth  output  $clog2(DEPTH)+1  current stack occupancy.

Function
REQ-014 SHALL implement states RUN, DRAIN, EMIT.
REQ-015 Instruction transfer SHALL occur only on clk edge with in_valid && in_ready; in_ready = 1 in RUN and DRAIN, 0 in EMIT.
REQ-016 Result transfer SHALL occur on clk edge with res_valid && res_ready; res_valid = 1 only in EMIT.
REQ-017 In RUN, one instruction SHALL execute per accepted transfer, stack updated at that edge (latency 1 cycle).
REQ-018 PUSH: needs depth<DEPTH; pushes in_operand; depth+1.
REQ-019 ADD/SUB/MUL: need depth>=2; pop b (top) then a; push a+b, a-b, a*b; depth-1.
REQ-020 Arithmetic SHALL be modulo 2^DATA_W (two's complement wrap); MUL keeps low DATA_W bits; no overflow flag.
REQ-021 NEG: needs depth>=1; replaces top with 0-top (wrap).
REQ-022 DUP: needs 1<=depth<DEPTH; pushes copy of top; depth+1.
REQ-023 POP: needs depth>=1; discards top; depth-1.
REQ-024 Operand shortage SHALL set error UNDERFLOW; PUSH/DUP at depth==DEPTH SHALL set OVERFLOW (underflow wins if both, e.g. DUP at depth 0); stack unchanged; state -> DRAIN.
REQ-025 END in RUN with depth==1: res_data <= top, res_err <= 0, state -> EMIT.
REQ-026 END in RUN with depth!=1: res_data <= 0, res_err <= BAD_END, state -> EMIT.
REQ-027 DRAIN SHALL discard accepted non-END instructions without stack change; END -> EMIT with res_data 0 and first latched error code.
REQ-028 res_data/res_err SHALL hold stable while res_valid && !res_ready.
REQ-029 On result transfer: depth <= 0, error latch cleared, state -> RUN; in_ready rises next cycle.
REQ-030 Stack storage contents beyond depth are don't-care; depth output SHALL always equal occupancy.

Reset
REQ-031 While rst=1 (asynchronously on assertion): state RUN, depth 0, in_ready 1, res_valid 0, res_data 0, res_err 0, error latch cleared.
REQ-032 Reset mid-program or during EMIT SHALL discard the stack and any pending result; no result emitted for that program.
REQ-033 First transfer possible on first clk edge after rst deasserts.

Verification
REQ-034 PUSH 3, PUSH 4, ADD, PUSH 5, MUL, END -> one result res_data 35, res_err 0; in_ready 0 until res_ready.
REQ-035 DATA_W=32: PUSH 0xFFFFFFFF, PUSH 2, ADD, END -> res_data 1; PUSH 0, NEG... PUSH 1, NEG, END -> 0xFFFFFFFF.
REQ-036 ADD with depth 1, then PUSH 9, END -> res_data 0, res_err 1; PUSH not applied (depth stays 1 during DRAIN).
REQ-037 DEPTH=16: 16 PUSH, DUP, END -> res_err 2; PUSH 1, PUSH 2, END -> res_err 3.
REQ-038 Hold res_ready=0 for 5 cycles in EMIT with in_valid=1 -> res_data stable, no instruction accepted; then res_ready=1 -> next program runs from depth 0.
REQ-039 Assert rst after PUSH 7, PUSH 8 -> depth 0, res_valid 0; subsequent PUSH 2, END -> res_data 2.
